output_port_arbiter: RTL

Round-robin scheduler that shares a leaf's single BFT injection path between NUM_PORTS Output_Port instances. It drives each port's one-hot rd_en_sel and OR-merges the ports' internal_out buses into one registered packet stream. Grants are bursted up to MAX_BURST reads per port. A port that is stalled on freespace credit is skipped after STALL_LIMIT missed reads. The block sits between the Output_Port array and the leaf interface, in the clk_bft domain.

---
 rtl/output_port_arbiter_pkg.sv | 16 +
 rtl/output_port_arbiter_pick.sv | 33 +++
 rtl/output_port_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/output_port_arbiter_pkg.sv
// Shared constants and helpers for the output port arbiter.
// Holds the FSM encoding, pointer-width helper and valid-bit index helper.
package output_port_arbiter_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    function automatic int ptr_bits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int vld_bit(input int pb);
        return pb - 1;
    endfunction

endpackage

// File: rtl/output_port_arbiter_pick.sv
// Combinational round-robin search: first set request at or after start_i,
// wrapping modulo NUM_PORTS.
module rr_priority_pick
    import output_port_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 8,
    parameter int PTR_BITS  = ptr_bits(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [PTR_BITS-1:0]  start_i,
    output logic                 found_o,
    output logic [PTR_BITS-1:0]  idx_o
);

    logic [PTR_BITS:0] pos;

    // Walk from the farthest offset down so the nearest request wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        pos     = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            pos = {1'b0, start_i} + (PTR_BITS+1)'(k);
            if (pos >= (PTR_BITS+1)'(NUM_PORTS))
                pos = pos - (PTR_BITS+1)'(NUM_PORTS);
            if (req_i[pos[PTR_BITS-1:0]]) begin
                found_o = 1'b1;
                idx_o   = pos[PTR_BITS-1:0];
            end
        end
    end

endmodule

// File: rtl/output_port_arbiter.sv
// Round-robin burst scheduler sharing one BFT injection path between
// Output_Port instances; merges their outputs into one registered stream.
module output_port_arbiter
    import output_port_arbiter_pkg::*;
#(
    parameter int NUM_PORTS   = 8,
    parameter int PACKET_BITS = 97,
    parameter int MAX_BURST   = 4,
    parameter int STALL_LIMIT = 3,
    localparam int PTR_BITS   = ptr_bits(NUM_PORTS)
) (
    input  logic                             clk_bft,
    input  logic                             reset_bft,
    input  logic [NUM_PORTS-1:0]             empty,
    input  logic [NUM_PORTS*PACKET_BITS-1:0] internal_out_flat,
    input  logic                             out_ready,
    output logic [NUM_PORTS-1:0]             rd_en_sel,
    output logic [PACKET_BITS-1:0]           packet_out,
    output logic                             packet_vld,
    output logic [PTR_BITS-1:0]              grant_idx,
    output logic                             collision_err
);

    localparam int VLD = vld_bit(PACKET_BITS);

    logic [0:0]             state_q, state_d;
    logic [PTR_BITS-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PTR_BITS-1:0]    grant_q, grant_d;
    logic [3:0]             burst_q, burst_d;
    logic [3:0]             miss_q, miss_d;
    logic                   issue_q;
    logic [PACKET_BITS-1:0] pkt_q;
    logic                   coll_q;

    logic [PACKET_BITS-1:0] merged;
    logic [NUM_PORTS-1:0]   vld_vec;
    logic                   multi_vld;
    logic                   pick_found;
    logic [PTR_BITS-1:0]    pick_idx;
    logic [PTR_BITS-1:0]    nxt_ptr;
    logic                   issue, hit, miss, leave;

    rr_priority_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_BITS  (PTR_BITS)
    ) u_pick (
        .req_i   (~empty),
        .start_i (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_comb begin
        merged  = '0;
        vld_vec = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            merged     = merged | internal_out_flat[i*PACKET_BITS +: PACKET_BITS];
            vld_vec[i] = internal_out_flat[i*PACKET_BITS + VLD];
        end
    end

    // More than one valid bit: clearing the lowest set bit leaves something.
    assign multi_vld = |(vld_vec & (vld_vec - 1'b1));

    assign issue = (state_q == ST_GRANT) && out_ready && !empty[grant_q];
    assign hit   = issue_q && vld_vec[grant_q];
    assign miss  = issue_q && !vld_vec[grant_q];

    assign nxt_ptr = (grant_q == PTR_BITS'(NUM_PORTS - 1)) ?
                     '0 : grant_q + 1'b1;

    assign leave = (empty[grant_q] && !issue)
                || (issue && burst_q == 4'(MAX_BURST - 1))
                || (miss && miss_q == 4'(STALL_LIMIT - 1));

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        burst_d  = burst_q;
        miss_d   = miss_q;
        unique case (state_q)
            ST_IDLE: begin
                if (out_ready && pick_found) begin
                    grant_d = pick_idx;
                    burst_d = '0;
                    miss_d  = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (issue)
                    burst_d = burst_q + 1'b1;
                if (hit)
                    miss_d = '0;
                else if (miss && miss_q != 4'hF)
                    miss_d = miss_q + 1'b1;
                if (leave) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = nxt_ptr;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_bft or posedge reset_bft) begin
        if (reset_bft) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            burst_q  <= '0;
            miss_q   <= '0;
            issue_q  <= 1'b0;
            pkt_q    <= '0;
            coll_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            burst_q  <= burst_d;
            miss_q   <= miss_d;
            issue_q  <= issue;
            pkt_q    <= merged;
            coll_q   <= coll_q | multi_vld;
        end
    end

    assign rd_en_sel     = issue ? (NUM_PORTS'(1) << grant_q) : '0;
    assign packet_out    = pkt_q;
    assign packet_vld    = pkt_q[VLD];
    assign grant_idx     = grant_q;
    assign collision_err = coll_q;

endmodule
